// File: rtl/pkt_desc_sched.sv
// Descriptor scheduler: CSR-fed descriptor queue that issues packets to the read controller.
// Optional completion interrupt enabled by defining PKT_DESC_SCHED_IRQ_EN.
module pkt_desc_sched #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        csr_address,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  input  logic              csr_read,
  output logic [31:0]       csr_readdata,
  output logic              rd_start,
  output logic [ADDR_W-1:0] pkt_begin,
  output logic [ADDR_W-1:0] pkt_end,
  input  logic              rd_done,
  output logic              busy,
  output logic              irq
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              enable_q, enable_d;
  logic              ovf_q, ovf_d, bad_q, bad_d;
  logic [ADDR_W-1:0] stage_q, stage_d;
  logic [31:0]       done_cnt_q, done_cnt_d;
  logic [31:0]       gap_cnt_q, gap_cnt_d;
  logic              busy_q, busy_d;
  logic              rd_start_q, rd_start_d;
  logic [ADDR_W-1:0] pkt_begin_q, pkt_begin_d, pkt_end_q, pkt_end_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_en_s, irq_pend_s;

  logic [ADDR_W-1:0] mem_begin_q [DEPTH];
  logic [ADDR_W-1:0] mem_end_q   [DEPTH];

  logic wr_ctrl, flush, clr_ovf, wr_begin, push_req, clr_cnt;
  logic full, empty, desc_bad, push_ok, pop, done_acc;
  logic [31:0] rmux;

  assign wr_ctrl  = csr_write && (csr_address == 3'd0);
  assign flush    = wr_ctrl && csr_writedata[1];
  assign clr_ovf  = wr_ctrl && csr_writedata[2];
  assign wr_begin = csr_write && (csr_address == 3'd1);
  assign push_req = csr_write && (csr_address == 3'd2);
  assign clr_cnt  = csr_write && (csr_address == 3'd4);
  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign desc_bad = push_req && (csr_writedata[ADDR_W-1:0] <= stage_q);
  // flush wins over a coincident push; it also blocks the pop in the same cycle
  assign push_ok  = push_req && !full && !desc_bad && !flush;
  assign pop      = (state_q == S_IDLE) && enable_q && !empty && !flush;
  assign done_acc = (state_q == S_WAIT) && rd_done;

`ifdef PKT_DESC_SCHED_IRQ_EN
  logic irq_en_q, irq_en_d, irq_pend_q, irq_pend_d;
  assign irq_en_s   = irq_en_q;
  assign irq_pend_s = irq_pend_q;

  always_comb begin
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    if (wr_ctrl) irq_en_d = csr_writedata[3];
    // a completion in the same cycle as an ack keeps the interrupt pending
    if (done_acc)                            irq_pend_d = 1'b1;
    else if (wr_ctrl && csr_writedata[4])    irq_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq = irq_pend_q && irq_en_q;
`else
  assign irq_en_s   = 1'b0;
  assign irq_pend_s = 1'b0;
  assign irq        = 1'b0;
`endif

  always_comb begin
    rmux = '0;
    case (csr_address)
      3'd0:    rmux = {27'b0, 1'b0, irq_en_s, 2'b0, enable_q};
      3'd3:    rmux = {17'b0, irq_pend_s, bad_q, ovf_q, busy_q, empty, full, 9'(count_q)};
      3'd4:    rmux = done_cnt_q;
      default: rmux = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    enable_d    = enable_q;
    ovf_d       = ovf_q;
    bad_d       = bad_q;
    stage_d     = stage_q;
    done_cnt_d  = done_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    busy_d      = busy_q;
    rd_start_d  = 1'b0;
    pkt_begin_d = pkt_begin_q;
    pkt_end_d   = pkt_end_q;
    rdata_d     = csr_read ? rmux : 32'd0;

    if (wr_ctrl)  enable_d = csr_writedata[0];
    if (wr_begin) stage_d  = csr_writedata[ADDR_W-1:0];

    if (clr_ovf) begin
      ovf_d = 1'b0;
      bad_d = 1'b0;
    end else begin
      if (push_req && full) ovf_d = 1'b1;
      if (desc_bad)         bad_d = 1'b1;
    end

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PW+1)'(push_ok) - (PW+1)'(pop);
    end

    // a clear coinciding with a completion leaves the count at 1
    if (clr_cnt) done_cnt_d = 32'(done_acc);
    else         done_cnt_d = done_cnt_q + 32'(done_acc);

    case (state_q)
      S_IDLE: if (pop) begin
        pkt_begin_d = mem_begin_q[rd_ptr_q];
        pkt_end_d   = mem_end_q[rd_ptr_q];
        busy_d      = 1'b1;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        rd_start_d = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: if (rd_done) begin
        if (GAP_CYCLES == 0) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = 32'(GAP_CYCLES);
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= 32'd1) begin
          gap_cnt_d = '0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      enable_q    <= 1'b0;
      ovf_q       <= 1'b0;
      bad_q       <= 1'b0;
      stage_q     <= '0;
      done_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      busy_q      <= 1'b0;
      rd_start_q  <= 1'b0;
      pkt_begin_q <= '0;
      pkt_end_q   <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      enable_q    <= enable_d;
      ovf_q       <= ovf_d;
      bad_q       <= bad_d;
      stage_q     <= stage_d;
      done_cnt_q  <= done_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      busy_q      <= busy_d;
      rd_start_q  <= rd_start_d;
      pkt_begin_q <= pkt_begin_d;
      pkt_end_q   <= pkt_end_d;
      rdata_q     <= rdata_d;
    end
  end

  // queue storage holds data only, so it carries no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_begin_q[wr_ptr_q] <= stage_q;
      mem_end_q[wr_ptr_q]   <= csr_writedata[ADDR_W-1:0];
    end
  end

  assign csr_readdata = rdata_q;
  assign rd_start     = rd_start_q;
  assign pkt_begin    = pkt_begin_q;
  assign pkt_end      = pkt_end_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pkt_desc_sched.sv
// Bench for pkt_desc_sched: descriptor table with STATUS expectations plus
// hand-written sequences for latency, gap, enable/flush, interrupt and reset cases.
module tb_pkt_desc_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  csr_address = '0;
  logic        csr_write = 1'b0;
  logic [31:0] csr_writedata = '0;
  logic        csr_read = 1'b0;
  logic [31:0] csr_readdata;
  logic        rd_start;
  logic [31:0] pkt_begin, pkt_end;
  logic        rd_done = 1'b0;
  logic        busy, irq;

  pkt_desc_sched #(.DEPTH(8), .GAP_CYCLES(2), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
    .csr_read(csr_read), .csr_readdata(csr_readdata),
    .rd_start(rd_start), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .rd_done(rd_done), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rd_start_cnt = 0;
  logic [63:0] sb[$];

  always @(negedge clk) if (rd_start) rd_start_cnt <= rd_start_cnt + 1;

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
    bit          acc;
    logic [14:0] st;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(posedge clk); #1;
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_address = a; csr_read = 1'b1;
    @(posedge clk); #1;
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic push(input logic [31:0] b, input logic [31:0] e, input bit acc);
    csr_wr(3'd1, b);
    csr_wr(3'd2, e);
    if (acc) sb.push_back({b, e});
  endtask

  task automatic sb_cmp();
    logic [63:0] exp;
    if (sb.size() == 0) begin
      chk("unexpected_rd_start", {pkt_begin, pkt_end}, 64'd0);
    end else begin
      exp = sb.pop_front();
      chk("issued_desc", {pkt_begin, pkt_end}, exp);
    end
  endtask

  // waits (bounded) for rd_start, checks the descriptor, optionally completes it after lat cycles
  task automatic serve(input int lat, input bit do_done);
    int t;
    t = 0;
    while (!rd_start && t < 300) begin @(posedge clk); #1; t++; end
    if (!rd_start) begin
      chk("rd_start_timeout", 64'd0, 64'd1);
    end else begin
      sb_cmp();
      if (do_done) begin
        repeat (lat) begin @(posedge clk); #1; end
        rd_done = 1'b1;
        @(posedge clk); #1;
        rd_done = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 300) begin @(posedge clk); #1; t++; end
    if (busy) chk("busy_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int base;

    tbl[0]  = '{32'h3000, 32'h3010, 1'b1, 15'h0001};
    tbl[1]  = '{32'h2000, 32'h2000, 1'b0, 15'h2001};
    tbl[2]  = '{32'h3100, 32'h3110, 1'b1, 15'h2002};
    tbl[3]  = '{32'h2100, 32'h20ff, 1'b0, 15'h2002};
    tbl[4]  = '{32'h3200, 32'h3210, 1'b1, 15'h2003};
    tbl[5]  = '{32'h3300, 32'h3310, 1'b1, 15'h2004};
    tbl[6]  = '{32'h3400, 32'h3410, 1'b1, 15'h2005};
    tbl[7]  = '{32'h3500, 32'h3510, 1'b1, 15'h2006};
    tbl[8]  = '{32'h3600, 32'h3610, 1'b1, 15'h2007};
    tbl[9]  = '{32'h3700, 32'h3710, 1'b1, 15'h2208};
    tbl[10] = '{32'h3800, 32'h3810, 1'b0, 15'h3208};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {rd_start, busy, irq, pkt_begin, pkt_end, csr_readdata},
        {3'b0, 32'd0, 32'd0, 32'd0});
    reset = 1'b1;
    csr_rd(3'd3, rd); chk("rst_status", rd, 32'h400);
    csr_rd(3'd0, rd); chk("rst_ctrl", rd, 32'h0);
    csr_rd(3'd4, rd); chk("rst_done_cnt", rd, 32'h0);

    // single packet: latency, hold, gap
    push(32'h1000, 32'h1040, 1'b1);
    csr_wr(3'd0, 32'h1);
    @(posedge clk); #1; chk("lat_cycle1_no_start", rd_start, 1'b0);
    @(posedge clk); #1; chk("lat_cycle2_start", rd_start, 1'b1);
    sb_cmp();
    chk("busy_at_issue", busy, 1'b1);
    @(posedge clk); #1; chk("start_one_cycle", rd_start, 1'b0);
    repeat (19) begin @(posedge clk); #1; end
    chk("hold_in_wait", {pkt_begin, pkt_end}, {32'h1000, 32'h1040});
    rd_done = 1'b1; @(posedge clk); #1; rd_done = 1'b0;
    chk("busy_gap0", busy, 1'b1);
    @(posedge clk); #1; chk("busy_gap1", busy, 1'b1);
    @(posedge clk); #1; chk("busy_after_gap", busy, 1'b0);
    csr_rd(3'd4, rd); chk("done_cnt_1", rd, 32'd1);
    csr_wr(3'd0, 32'h0);

    // descriptor table with enable off: level, full, overflow, bad_desc
    for (int i = 0; i < 11; i++) begin
      push(tbl[i].b, tbl[i].e, tbl[i].acc);
      csr_rd(3'd3, rd);
      chk($sformatf("tbl_status_%0d", i), rd, {17'b0, tbl[i].st});
    end

    // drain the full queue in push order
    base = rd_start_cnt;
    csr_wr(3'd0, 32'h1);
    for (int i = 0; i < 8; i++) serve(4, 1'b1);
    wait_idle();
    repeat (10) @(posedge clk);
    #1;
    chk("drain_start_count", rd_start_cnt - base, 8);
    chk("drain_sb_empty", sb.size(), 0);
    csr_rd(3'd4, rd); chk("done_cnt_9", rd, 32'd9);
    csr_rd(3'd3, rd); chk("status_sticky", rd, 32'h3400);
    csr_wr(3'd0, 32'h5);
    csr_rd(3'd3, rd); chk("status_clr_ovf", rd, 32'h400);
    csr_rd(3'd0, rd); chk("ctrl_readback", rd, 32'h1);

    // equal begin/end with enable on: dropped, nothing issued
    base = rd_start_cnt;
    push(32'h2000, 32'h2000, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("bad_no_start", rd_start_cnt - base, 0);
    csr_rd(3'd3, rd); chk("bad_status", rd, 32'h2400);
    csr_wr(3'd0, 32'h5);

    // disable during WAIT, then flush and re-enable
    csr_wr(3'd4, 32'h0);
    csr_wr(3'd0, 32'h0);
    push(32'h4000, 32'h4100, 1'b1);
    push(32'h4200, 32'h4300, 1'b1);
    push(32'h4400, 32'h4500, 1'b1);
    csr_wr(3'd0, 32'h1);
    serve(0, 1'b0);
    csr_wr(3'd0, 32'h0);
    repeat (5) begin @(posedge clk); #1; end
    rd_done = 1'b1; @(posedge clk); #1; rd_done = 1'b0;
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    csr_rd(3'd4, rd); chk("disable_done_cnt", rd, 32'd1);
    csr_rd(3'd3, rd); chk("disable_level", rd, 32'h2);
    csr_wr(3'd0, 32'h2);
    sb.delete();
    csr_rd(3'd3, rd); chk("flush_empty", rd, 32'h400);
    base = rd_start_cnt;
    csr_wr(3'd0, 32'h1);
    repeat (15) @(posedge clk);
    #1;
    chk("flush_no_start", rd_start_cnt - base, 0);

    // stray rd_done while idle is ignored
    rd_done = 1'b1; @(posedge clk); #1; rd_done = 1'b0;
    csr_rd(3'd4, rd); chk("stray_done_ignored", rd, 32'd1);

    // DONE_CNT clear coinciding with a completion
    push(32'h5000, 32'h5080, 1'b1);
    serve(0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    csr_address = 3'd4; csr_writedata = 32'h0; csr_write = 1'b1; rd_done = 1'b1;
    @(posedge clk); #1;
    csr_write = 1'b0; rd_done = 1'b0;
    wait_idle();
    csr_rd(3'd4, rd); chk("clr_with_inc", rd, 32'd1);

`ifdef PKT_DESC_SCHED_IRQ_EN
    csr_wr(3'd0, 32'h9);
    push(32'h6000, 32'h6010, 1'b1);
    push(32'h6100, 32'h6110, 1'b1);
    serve(3, 1'b1);
    chk("irq_after_done", irq, 1'b1);
    serve(0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    csr_address = 3'd0; csr_writedata = 32'h19; csr_write = 1'b1; rd_done = 1'b1;
    @(posedge clk); #1;
    csr_write = 1'b0; rd_done = 1'b0;
    chk("irq_ack_vs_done", irq, 1'b1);
    csr_rd(3'd3, rd); chk("status_irq_pending", rd[14], 1'b1);
    wait_idle();
    csr_wr(3'd0, 32'h19);
    chk("irq_after_ack", irq, 1'b0);
    csr_rd(3'd3, rd); chk("status_irq_cleared", rd[14], 1'b0);
`else
    csr_wr(3'd0, 32'h9);
    push(32'h6000, 32'h6010, 1'b1);
    serve(3, 1'b1);
    chk("irq_tied_low", irq, 1'b0);
    csr_rd(3'd3, rd); chk("status_irq_zero", rd[14], 1'b0);
    csr_rd(3'd0, rd); chk("ctrl_irq_en_ignored", rd, 32'h1);
    wait_idle();
`endif

    // reset while waiting for completion
    csr_wr(3'd0, 32'h0);
    push(32'h7000, 32'h7100, 1'b1);
    push(32'h7200, 32'h7300, 1'b1);
    csr_wr(3'd0, 32'h1);
    serve(0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    chk("rstw_outputs", {busy, rd_start, irq, pkt_begin}, {3'b0, 32'd0});
    csr_rd(3'd3, rd); chk("rstw_status", rd, 32'h400);
    csr_rd(3'd4, rd); chk("rstw_done_cnt", rd, 32'd0);
    base = rd_start_cnt;
    rd_done = 1'b1; @(posedge clk); #1; rd_done = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    csr_rd(3'd4, rd); chk("rstw_late_done", rd, 32'd0);
    chk("rstw_no_start", rd_start_cnt - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
